class_sweep_controller: RTL and testbench



---
 rtl/class_sweep_controller.sv | 101 ++++++++++
 tb/tb_class_sweep_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/class_sweep_controller.sv
// class_sweep_controller: sweeps class memory segments per query and reports the best-scoring class (CLASS_SWEEP_SIGNED_EN selects signed scores)
module class_sweep_controller #(
  parameter int MAX_CLASSES    = 32,
  parameter int SEGS           = 4,
  parameter int CLA_ADDR_WIDTH = 10,
  parameter int SCORE_W        = 16,
  parameter int CNT_W          = $clog2(MAX_CLASSES) + 1
) (
  input  logic                      clk,
  input  logic                      reset_in,
  input  logic [CNT_W-1:0]          class_num,
  input  logic [CLA_ADDR_WIDTH-1:0] base_addr,
  input  logic                      start,
  output logic                      busy,
  output logic                      addr_valid,
  input  logic                      addr_ready,
  output logic [CLA_ADDR_WIDTH-1:0] class_addr,
  output logic [CNT_W-1:0]          class_idx,
  output logic                      last_seg,
  input  logic                      score_valid,
  input  logic [SCORE_W-1:0]        score,
  output logic                      done,
  output logic [CNT_W-1:0]          best_class,
  output logic [SCORE_W-1:0]        best_score
);
  localparam int SEG_W = SEGS > 1 ? $clog2(SEGS) : 1;
`ifdef CLASS_SWEEP_SIGNED_EN
  localparam logic [SCORE_W-1:0] INIT = {1'b1, {(SCORE_W-1){1'b0}}};
`else
  localparam logic [SCORE_W-1:0] INIT = '0;
`endif
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] n_lat, idx, cnt, cnt_nxt, clamp;
  logic [SEG_W-1:0] seg;
  logic [CLA_ADDR_WIDTH-1:0] addr;
  logic go, hs, seg_end, last_hs, acc, gt;
  assign go         = state == IDLE && start;
  assign clamp      = class_num > CNT_W'(MAX_CLASSES) ? CNT_W'(MAX_CLASSES) : class_num;
  assign hs         = state == SWEEP && addr_ready;
  assign seg_end    = seg == SEG_W'(SEGS - 1);
  assign last_hs    = hs && seg_end && idx == n_lat - CNT_W'(1);
  assign acc        = score_valid && (state == SWEEP || state == DRAIN) && cnt < n_lat;
  assign cnt_nxt    = cnt + CNT_W'(acc);
`ifdef CLASS_SWEEP_SIGNED_EN
  assign gt         = $signed(score) > $signed(best_score);
`else
  assign gt         = score > best_score;
`endif
  assign busy       = state != IDLE;
  assign addr_valid = state == SWEEP;
  assign done       = state == DONE;
  assign last_seg   = addr_valid && seg_end;
  assign class_addr = addr;
  assign class_idx  = idx;
  // state register
  always_ff @(posedge clk) state <= reset_in ? IDLE : nxt;
  // next state: sweep until the last segment handshake, then wait for every score
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = go ? (clamp == '0 ? DONE : SWEEP) : IDLE;
      SWEEP:   nxt = last_hs ? DRAIN : SWEEP;
      DRAIN:   nxt = cnt_nxt == n_lat ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  // address walk and best-score tracking; ties keep the earlier class
  always_ff @(posedge clk) begin
    if (reset_in) begin
      n_lat      <= '0;
      idx        <= '0;
      seg        <= '0;
      addr       <= '0;
      cnt        <= '0;
      best_class <= '0;
      best_score <= INIT;
    end else if (go) begin
      n_lat      <= clamp;
      idx        <= '0;
      seg        <= '0;
      addr       <= base_addr;
      cnt        <= '0;
      best_class <= '0;
      best_score <= INIT;
    end else begin
      if (hs) begin
        addr <= addr + CLA_ADDR_WIDTH'(1);
        seg  <= seg_end ? '0 : seg + SEG_W'(1);
        if (seg_end) idx <= idx + CNT_W'(1);
      end
      if (acc) begin
        cnt <= cnt_nxt;
        if (gt) begin
          best_class <= cnt;
          best_score <= score;
        end
      end
    end
  end
endmodule

// File: tb/tb_class_sweep_controller.sv
// tb_class_sweep_controller: randomized sweeps checked against a list-based model of addresses and best score
module tb_class_sweep_controller;
  localparam int SEGS = 4;
  localparam int MAXC = 32;
`ifdef CLASS_SWEEP_SIGNED_EN
  localparam logic [15:0] INIT = 16'h8000;
`else
  localparam logic [15:0] INIT = 16'h0000;
`endif
  logic clk = 1'b0;
  logic reset_in, start, busy, addr_valid, addr_ready, last_seg, score_valid, done;
  logic [5:0] class_num, class_idx, best_class;
  logic [9:0] base_addr, class_addr;
  logic [15:0] score, best_score;
  logic [15:0] sc [0:63];
  logic [15:0] lbs;
  int lbc;
  int checks = 0;
  int errors = 0;
  int cyc;
  always #5 clk = ~clk;
  class_sweep_controller dut (
    .clk(clk), .reset_in(reset_in), .class_num(class_num), .base_addr(base_addr),
    .start(start), .busy(busy), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .class_addr(class_addr), .class_idx(class_idx), .last_seg(last_seg),
    .score_valid(score_valid), .score(score), .done(done),
    .best_class(best_class), .best_score(best_score)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  function automatic logic gt(input logic [15:0] a, input logic [15:0] b);
`ifdef CLASS_SWEEP_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction
  task automatic run_sweep(input string tag, input int nreq, input logic [9:0] base, input int mode, input bit poke);
    int n, total, k, j, c, ebc;
    logic [15:0] mx;
    logic [9:0] ea;
    bit hs, sv;
    n = nreq > MAXC ? MAXC : nreq;
    total = n * SEGS;
    mx = INIT;
    ebc = 0;
    for (int i = 0; i < n; i++) if (gt(sc[i], mx)) mx = sc[i];
    for (int i = n - 1; i >= 0; i--) if (sc[i] == mx) ebc = i;
    @(negedge clk);
    class_num = 6'(nreq);
    base_addr = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    class_num = 6'($urandom);
    base_addr = 10'($urandom);
    chk({tag, " busy"}, busy, 1);
    k = 0;
    j = 0;
    c = 0;
    while (j < n && c < 3000) begin
      addr_ready = mode == 0 ? 1'b1 : mode == 1 ? ~c[0] : 1'($urandom);
      chk({tag, " valid"}, addr_valid, k < total);
      if (addr_valid) begin
        ea = base + 10'(k);
        chk({tag, " addr"}, class_addr, ea);
        chk({tag, " idx"}, class_idx, k / SEGS);
        chk({tag, " last"}, last_seg, k % SEGS == SEGS - 1);
      end
      chk({tag, " early done"}, done, 0);
      sv = (j < n - 1 || k == total) && 1'($urandom);
      score_valid = sv;
      score = sc[j];
      start = poke && k == 5;
      hs = addr_valid && addr_ready;
      @(posedge clk);
      k += int'(hs);
      j += int'(sv);
      @(negedge clk);
      c++;
    end
    score_valid = 1'b0;
    start = 1'b0;
    addr_ready = 1'b0;
    chk({tag, " timeout"}, c < 3000, 1);
    chk({tag, " handshakes"}, k, total);
    chk({tag, " no valid"}, addr_valid, 0);
    chk({tag, " done"}, done, 1);
    chk({tag, " best_class"}, best_class, ebc);
    chk({tag, " best_score"}, best_score, mx);
    @(negedge clk);
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " idle"}, busy, 0);
    chk({tag, " hold"}, best_score, mx);
    lbc = ebc;
    lbs = mx;
  endtask
  initial begin
    reset_in = 1'b1;
    start = 1'b0;
    class_num = '0;
    base_addr = '0;
    addr_ready = 1'b0;
    score_valid = 1'b0;
    score = '0;
    repeat (3) @(negedge clk);
    reset_in = 1'b0;
    chk("rst valid", addr_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst last", last_seg, 0);
    chk("rst addr", class_addr, 0);
    chk("rst idx", class_idx, 0);
    chk("rst bc", best_class, 0);
    chk("rst bs", best_score, INIT);
    sc[0] = 16'd5; sc[1] = 16'd9; sc[2] = 16'd7;
    run_sweep("basic", 3, 10'h100, 0, 0);
    @(negedge clk);
    score_valid = 1'b1;
    score = 16'h7FFF;
    @(negedge clk);
    score_valid = 1'b0;
    chk("idle score bc", best_class, lbc);
    chk("idle score bs", best_score, lbs);
    sc[0] = 16'd9; sc[1] = 16'd9; sc[2] = 16'd3;
    run_sweep("bp", 3, 10'h100, 1, 0);
    sc[0] = 16'hFFFC; sc[1] = 16'hFFFE; sc[2] = 16'hFFF8;
    run_sweep("sgn", 3, 10'h200, 2, 0);
    run_sweep("zero", 0, 10'h055, 0, 0);
    for (int i = 0; i < 64; i++) sc[i] = 16'($urandom);
    run_sweep("clamp", 40, 10'h000, 2, 0);
    sc[0] = 16'd1; sc[1] = 16'd2;
    run_sweep("wrap", 2, 10'h3FE, 0, 0);
    for (int i = 0; i < 8; i++) sc[i] = 16'($urandom_range(0, 6));
    run_sweep("poke", 4, 10'h080, 2, 1);
    @(negedge clk);
    class_num = 6'd5;
    base_addr = 10'h040;
    start = 1'b1;
    addr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    score_valid = 1'b1;
    score = 16'd50;
    @(negedge clk);
    score_valid = 1'b0;
    cyc = 0;
    while (class_idx != 6'd2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort reach", cyc < 100, 1);
    chk("abort pre bs", best_score, 50);
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;
    addr_ready = 1'b0;
    chk("abort valid", addr_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort addr", class_addr, 0);
    chk("abort bc", best_class, 0);
    chk("abort bs", best_score, INIT);
    @(negedge clk);
    class_num = 6'd1;
    base_addr = 10'h020;
    start = 1'b1;
    addr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    score_valid = 1'b1;
    score = 16'd3;
    @(negedge clk);
    score = 16'h7FFF;
    @(negedge clk);
    score_valid = 1'b0;
    cyc = 0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    addr_ready = 1'b0;
    chk("extra timeout", cyc < 50, 1);
    chk("extra bc", best_class, 0);
    chk("extra bs", best_score, 3);
    @(negedge clk);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 16; i++) sc[i] = r[0] ? 16'($urandom) : 16'($urandom_range(0, 4));
      run_sweep("rand", $urandom_range(1, 10), 10'($urandom), 2, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
